// File: rtl/crypt_chan_arb.sv
// N-channel round-robin front end for the CCMP engine: FIFO staging, result routing, null-key bypass.
// Optional per-channel frame/abort counters are enabled with `define CRYPT_ARB_STATS_EN.
module crypt_chan_arb #(
  parameter int unsigned NCHAN      = 2,
  parameter int unsigned DW         = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PLW        = 16
) (
  input  logic                 macCoreClk,
  input  logic                 nPRst,
  input  logic                 nSRst,
  input  logic [NCHAN-1:0]     chReq,
  output logic [NCHAN-1:0]     chGrant,
  input  logic [NCHAN*PLW-1:0] chPayloadLen,
  input  logic [NCHAN-1:0]     chNullKey,
  input  logic [NCHAN-1:0]     chWrEn_p,
  input  logic [NCHAN*DW-1:0]  chData,
  input  logic [NCHAN-1:0]     chPayloadEnd_p,
  input  logic [NCHAN-1:0]     chAbort_p,
  output logic                 chFull,
  output logic                 engInit_p,
  output logic                 engAbort_p,
  output logic [PLW-1:0]       engPayloadLen,
  output logic [DW-1:0]        engData,
  output logic                 engValid,
  output logic                 engLast,
  input  logic                 engReady,
  input  logic [DW-1:0]        engOutData,
  input  logic                 engOutValid_p,
  input  logic                 engOutLast_p,
  output logic [DW-1:0]        outData,
  output logic [NCHAN-1:0]     outValid,
  output logic [NCHAN-1:0]     outLast,
  output logic                 ovfErr_p,
  output logic                 muxIsIdle,
`ifdef CRYPT_ARB_STATS_EN
  output logic [NCHAN*16-1:0]  statFrames,
  output logic [NCHAN*8-1:0]   statAborts,
`endif
  output logic [1:0]           muxCS
);

  localparam int unsigned CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StInit  = 2'd1,
    StData  = 2'd2,
    StDrain = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [NCHAN-1:0] grant_q, grant_d;
  logic [CW-1:0]    gidx_q, gidx_d;
  logic [CW-1:0]    rr_q, rr_d;
  logic [PLW-1:0]   len_q, len_d;
  logic             null_q, null_d;
  logic             init_q, init_d;
  logic             abort_q, abort_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [DW:0]      mem_q [FIFO_DEPTH];

  // Arbitration
  logic             arb_any, arb_hi_found;
  logic [CW-1:0]    arb_lo, arb_hi, arb_win;
  logic [PLW-1:0]   arb_len;
  logic             arb_null;

  always_comb begin
    arb_any      = 1'b0;
    arb_hi_found = 1'b0;
    arb_lo       = '0;
    arb_hi       = '0;
    // Descending scan leaves the lowest index overall and the lowest index at/after rr_q.
    for (int i = int'(NCHAN) - 1; i >= 0; i--) begin
      if (chReq[i]) begin
        arb_any = 1'b1;
        arb_lo  = CW'(i);
        if (CW'(i) >= rr_q) begin
          arb_hi_found = 1'b1;
          arb_hi       = CW'(i);
        end
      end
    end
    arb_win  = arb_hi_found ? arb_hi : arb_lo;
    arb_len  = '0;
    arb_null = 1'b0;
    for (int j = 0; j < int'(NCHAN); j++) begin
      if (CW'(j) == arb_win) begin
        arb_len  = chPayloadLen[j*PLW +: PLW];
        arb_null = chNullKey[j];
      end
    end
  end

  // Granted-channel input selection
  logic [DW-1:0] sel_data;
  logic          sel_wr, sel_end, sel_abort;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < int'(NCHAN); i++) begin
      if (grant_q[i]) sel_data = chData[i*DW +: DW];
    end
  end

  assign sel_wr    = (|(chWrEn_p & grant_q)) && (state_q == StData);
  assign sel_end   = |(chPayloadEnd_p & grant_q);
  assign sel_abort = |(chAbort_p & grant_q);

  // FIFO datapath
  logic          empty, full, pop, push, ovf, last_pop, eng_valid;
  logic [DW:0]   head;

  assign head      = mem_q[rd_ptr_q];
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign eng_valid = !empty && (state_q == StData) && !null_q;
  // Bypass frames drain the FIFO without any engine handshake.
  assign pop       = (state_q == StData) && !empty && (null_q || engReady);
  assign push      = sel_wr && (!full || pop);
  assign ovf       = sel_wr && full && !pop;
  assign last_pop  = pop && head[DW];

  always_ff @(posedge macCoreClk) begin
    if (push) mem_q[wr_ptr_q] <= {sel_end, sel_data};
  end

  logic [CW-1:0] rr_next;
  assign rr_next = (gidx_q == CW'(NCHAN - 1)) ? '0 : gidx_q + CW'(1);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    rr_d     = rr_q;
    len_d    = len_q;
    null_d   = null_q;
    init_d   = 1'b0;
    abort_d  = 1'b0;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop) cnt_d = cnt_q + (AW+1)'(1);
    if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);

    unique case (state_q)
      StIdle: begin
        if (arb_any) begin
          grant_d = {{(NCHAN-1){1'b0}}, 1'b1} << arb_win;
          gidx_d  = arb_win;
          len_d   = arb_len;
          null_d  = arb_null;
          state_d = StInit;
        end
      end
      StInit: begin
        if (len_q == '0) begin
          grant_d = '0;
          rr_d    = rr_next;
          state_d = StIdle;
        end else begin
          init_d  = !null_q;
          state_d = StData;
        end
      end
      StData: begin
        if (last_pop) begin
          if (null_q || engOutLast_p) begin
            grant_d = '0;
            rr_d    = rr_next;
            state_d = StIdle;
          end else begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (engOutLast_p) begin
          grant_d = '0;
          rr_d    = rr_next;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (sel_abort) begin
      state_d  = StIdle;
      grant_d  = '0;
      rr_d     = rr_next;
      init_d   = 1'b0;
      abort_d  = !null_q;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end

    // Soft reset mirrors the async reset and suppresses any abort pulse.
    if (!nSRst) begin
      state_d  = StIdle;
      grant_d  = '0;
      gidx_d   = '0;
      rr_d     = '0;
      len_d    = '0;
      null_d   = 1'b0;
      init_d   = 1'b0;
      abort_d  = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge macCoreClk or negedge nPRst) begin
    if (!nPRst) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_q     <= '0;
      len_q    <= '0;
      null_q   <= 1'b0;
      init_q   <= 1'b0;
      abort_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_q     <= rr_d;
      len_q    <= len_d;
      null_q   <= null_d;
      init_q   <= init_d;
      abort_q  <= abort_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Result routing
  logic routed;
  assign routed = (state_q == StData) || (state_q == StDrain);

  always_comb begin
    outValid = '0;
    outLast  = '0;
    outData  = '0;
    if (null_q) begin
      if (pop)      outValid = grant_q;
      if (last_pop) outLast  = grant_q;
      if (pop)      outData  = head[DW-1:0];
    end else if (routed) begin
      if (engOutValid_p) outValid = grant_q;
      if (engOutLast_p)  outLast  = grant_q;
      if (engOutValid_p) outData  = engOutData;
    end
    // Zero-length frame: completion marker only.
    if (state_q == StInit && len_q == '0) outLast = grant_q;
  end

  assign chGrant       = grant_q;
  assign chFull        = full;
  assign engInit_p     = init_q;
  assign engAbort_p    = abort_q;
  assign engPayloadLen = len_q;
  assign engValid      = eng_valid;
  assign engData       = eng_valid ? head[DW-1:0] : '0;
  assign engLast       = eng_valid && head[DW];
  assign ovfErr_p      = ovf;
  assign muxIsIdle     = (state_q == StIdle);
  assign muxCS         = state_q;

`ifdef CRYPT_ARB_STATS_EN
  logic        frame_done, abort_evt;
  logic [15:0] frames_q [NCHAN];
  logic [7:0]  aborts_q [NCHAN];

  assign frame_done = (state_q != StIdle) && (state_d == StIdle) && !sel_abort && nSRst;
  assign abort_evt  = sel_abort && nSRst;

  always_ff @(posedge macCoreClk or negedge nPRst) begin
    if (!nPRst) begin
      for (int i = 0; i < int'(NCHAN); i++) begin
        frames_q[i] <= '0;
        aborts_q[i] <= '0;
      end
    end else if (!nSRst) begin
      for (int i = 0; i < int'(NCHAN); i++) begin
        frames_q[i] <= '0;
        aborts_q[i] <= '0;
      end
    end else begin
      if (frame_done && frames_q[gidx_q] != '1) frames_q[gidx_q] <= frames_q[gidx_q] + 16'd1;
      if (abort_evt && aborts_q[gidx_q] != '1)  aborts_q[gidx_q] <= aborts_q[gidx_q] + 8'd1;
    end
  end

  for (genvar g = 0; g < int'(NCHAN); g++) begin : gen_stats
    assign statFrames[g*16 +: 16] = frames_q[g];
    assign statAborts[g*8 +: 8]   = aborts_q[g];
  end
`endif

endmodule
